// File: rtl/apb_mem_slave_param.sv
// -----------------------------------------------------------------------------
// apb_mem_slave_param
//
// Parametrised APB target memory for bus bring-up and verification.
// DEPTH words of DATA_WIDTH bits live at byte address BASE_ADDR. Writes honour
// PSTRB byte lanes. A fixed number of wait states is inserted in every access
// phase. Bad addresses complete with PSLVERR and have no side effects.
//
// Ports
//   PCLK      in   bus clock, rising edge
//   PRESETn   in   asynchronous active-low reset
//   PADDR     in   byte address            [ADDR_WIDTH-1:0]
//   PSEL      in   slave select
//   PENABLE   in   access phase marker
//   PWRITE    in   1 = write, 0 = read
//   PWDATA    in   write data              [DATA_WIDTH-1:0]
//   PSTRB     in   byte-lane write enables [DATA_WIDTH/8-1:0]
//   PRDATA    out  read data, registered at the setup edge
//   PREADY    out  transfer completion (combinational)
//   PSLVERR   out  transfer error, qualified by PREADY
// -----------------------------------------------------------------------------
module apb_mem_slave_param #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,   // 8, 16 or 32
  parameter int          DEPTH       = 16,   // power of two, >= 2
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0     // 0..15
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_W    = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,  state_d;
  logic [3:0]              cnt_q,    cnt_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;
  logic                    write_q,  write_d;
  logic                    err_q,    err_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode, evaluated on the live bus and captured at the setup edge
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;

  always_comb begin
    addr_off = PADDR - BASE_A;
    word_off = addr_off >> OFF_BITS;
    dec_idx  = word_off[IDX_W-1:0];
    // Below base (the subtraction wrapped), past the end, or not word aligned.
    dec_err  = (PADDR < BASE_A) ||
               (word_off >= DEPTH_A) ||
               ((PADDR & LOW_MASK) != '0);
  end

  // ---------------------------------------------------------------------------
  // Completion: only in ACCESS, with a live access phase and no wait left
  // ---------------------------------------------------------------------------
  logic pready;
  logic mem_we;

  assign pready = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
  assign mem_we = pready && write_q && !err_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    err_d    = err_q;
    prdata_d = prdata_q;

    unique case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high is a protocol violation: ignored.
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          idx_d    = dec_idx;
          write_d  = PWRITE;
          err_d    = dec_err;
          cnt_d    = WAIT_INIT;
          prdata_d = (!PWRITE && !dec_err) ? mem_q[dec_idx] : '0;
        end
      end

      ACCESS: begin
        if (!PSEL) begin
          // Master abort: drop the transfer without touching memory.
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Byte-lane write merge; PWDATA/PSTRB are taken at the completing edge.
  always_comb begin
    for (int w = 0; w < DEPTH; w++) begin
      mem_d[w] = mem_q[w];
    end
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (PSTRB[i]) begin
          mem_d[idx_q][8*i +: 8] = PWDATA[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  // NOTE: the storage is built from resettable flops rather than a RAM macro,
  // because reset must clear every word.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= mem_d[w];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PRDATA  = prdata_q;
  assign PREADY  = pready;
  assign PSLVERR = pready && err_q;

endmodule
